// File: rtl/key_debounce_multi_pkg.sv
// rtl/key_debounce_multi_pkg.sv - shared types and helpers for the multi-key debouncer
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } key_state_e;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

  // Pin level seen while the key is not pressed.
  function automatic logic released_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/key_debounce_multi_if.sv
// rtl/key_debounce_multi_if.sv - key pins in, debounced levels and event pulses out
interface key_debounce_multi_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] kin;
  logic [N_KEYS-1:0] kout;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] long_pulse;

  modport master (
    output kin,
    input  kout,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  modport slave (
    input  kin,
    output kout,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );
endinterface

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: synchroniser, debounce filter, hold FSM, pulses
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEB_CYC    = 5,
  parameter int LONG_CYC   = 20,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic kin_i,
  output logic kout_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int   DW      = $clog2(DEB_CYC);
  localparam int   HW      = $clog2(LONG_CYC);
  localparam logic REL_LVL = released_level(ACTIVE_LOW != 0);

  logic          sync1_q, sync2_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  key_state_e    state_q, state_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          pressed_raw;
  logic          kout;
  logic          differ;
  logic          flip;

  // XOR with the released level maps the pin to 1 = pressed for either polarity.
  assign pressed_raw = sync2_q ^ REL_LVL;
  assign kout        = (state_q != RELEASED);
  assign differ      = (pressed_raw != kout);
  assign flip        = differ && (deb_cnt_q == DW'(DEB_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= REL_LVL;
      sync2_q    <= REL_LVL;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      state_q    <= RELEASED;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      sync1_q    <= kin_i;
      sync2_q    <= sync1_q;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      state_q    <= state_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
    end
  end

  always_comb begin
    deb_cnt_d  = '0;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;

    if (differ && !flip) begin
      deb_cnt_d = deb_cnt_q + DW'(1);
    end

    // A debounced release always wins over a long-press threshold on the same edge.
    case (state_q)
      RELEASED: begin
        hold_cnt_d = '0;
        if (flip) begin
          state_d = PRESSED;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (flip) begin
          state_d    = RELEASED;
          release_d  = 1'b1;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HW'(LONG_CYC - 1)) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      LONG_HELD: begin
        if (flip) begin
          state_d    = RELEASED;
          release_d  = 1'b1;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RELEASED;
        hold_cnt_d = '0;
      end
    endcase
  end

  assign kout_o    = kout;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - N independent debounced key channels with press/release/long pulses
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int N_KEYS      = 4,
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  key_debounce_multi_if.slave  key_if
);

  localparam int DEB_CYC  = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);

  if (N_KEYS < 1) begin : g_bad_nkeys
    $error("key_debounce_multi: N_KEYS must be at least 1");
  end
  if (DEB_CYC < 2) begin : g_bad_deb
    $error("key_debounce_multi: debounce time must be at least 2 clock cycles");
  end
  if (LONG_CYC <= DEB_CYC) begin : g_bad_long
    $error("key_debounce_multi: long-press time must exceed debounce time");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEB_CYC    (DEB_CYC),
      .LONG_CYC   (LONG_CYC),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .kin_i     (key_if.kin[i]),
      .kout_o    (key_if.kout[i]),
      .press_o   (key_if.press_pulse[i]),
      .release_o (key_if.release_pulse[i]),
      .long_o    (key_if.long_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb/tb_key_debounce_multi.sv - randomized and directed checks against a cycle-level key model
module tb_key_debounce_multi;

  localparam int NK   = 2;
  localparam int DEB  = 5;
  localparam int LONG = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_debounce_multi_if #(.N_KEYS(NK)) key_if ();

  key_debounce_multi #(
    .N_KEYS      (NK),
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (5),
    .LONG_MS     (20),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key_if (key_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: pin history, consecutive-disagree count, time since press.
  logic [NK-1:0] m_h1, m_h2;
  int            m_dcnt [NK];
  int            m_age  [NK];
  bit            m_kout [NK];
  bit            m_fired[NK];
  logic [NK-1:0] e_kout, e_press, e_rel, e_long;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [NK-1:0] k, input logic r);
    bit p;
    e_press = '0;
    e_rel   = '0;
    e_long  = '0;
    if (r) begin
      m_h1 = '1;
      m_h2 = '1;
      for (int c = 0; c < NK; c++) begin
        m_dcnt[c] = 0; m_age[c] = 0; m_kout[c] = 0; m_fired[c] = 0;
      end
    end else begin
      for (int c = 0; c < NK; c++) begin
        p = ~m_h2[c];
        if (p != m_kout[c]) begin
          m_dcnt[c]++;
          if (m_dcnt[c] == DEB) begin
            m_kout[c] = p;
            m_dcnt[c] = 0;
            if (p) begin
              e_press[c] = 1'b1; m_age[c] = 0; m_fired[c] = 0;
            end else begin
              e_rel[c] = 1'b1;
            end
          end
        end else begin
          m_dcnt[c] = 0;
        end
        if (m_kout[c] && !e_press[c]) begin
          m_age[c]++;
          if (m_age[c] == LONG && !m_fired[c]) begin
            e_long[c] = 1'b1; m_fired[c] = 1;
          end
        end
      end
      m_h2 = m_h1;
      m_h1 = k;
    end
    for (int c = 0; c < NK; c++) e_kout[c] = m_kout[c];
  endtask

  task automatic step();
    logic [NK-1:0] k;
    logic          r;
    k = key_if.kin;
    r = rst;
    @(posedge clk);
    #1;
    cyc++;
    model_edge(k, r);
    check("kout",          32'(key_if.kout),          32'(e_kout));
    check("press_pulse",   32'(key_if.press_pulse),   32'(e_press));
    check("release_pulse", 32'(key_if.release_pulse), 32'(e_rel));
    check("long_pulse",    32'(key_if.long_pulse),    32'(e_long));
  endtask

  int            press_at, press_cyc, long_cyc, n_long, n_rel, n_press, len;
  logic [NK-1:0] seen;

  initial begin
    key_if.kin = 2'b11;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) step();
    check("idle_kout", 32'(key_if.kout), 32'd0);

    // Clean press on key 0: pulse DEB+2 cycles after the pin edge, long pulse LONG later.
    key_if.kin = 2'b10;
    press_at = -1; press_cyc = -1; long_cyc = -1; n_long = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (key_if.press_pulse[0] && press_at < 0) begin press_at = i; press_cyc = cyc; end
    end
    check("press_latency", 32'(press_at), 32'(DEB + 2));
    check("kout1_idle", 32'(key_if.kout[1]), 32'd0);
    for (int i = 0; i < 40; i++) begin
      step();
      if (key_if.long_pulse[0]) begin n_long++; long_cyc = cyc; end
    end
    check("long_count", 32'(n_long), 32'd1);
    check("long_delay", 32'(long_cyc - press_cyc), 32'(LONG));
    key_if.kin = 2'b11;
    n_rel = 0; n_long = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (key_if.release_pulse[0]) n_rel++;
      if (key_if.long_pulse[0]) n_long++;
    end
    check("release_count", 32'(n_rel), 32'd1);
    check("long_after_rel", 32'(n_long), 32'd0);

    // Glitch one sample shorter than the debounce window, then exactly the window.
    key_if.kin = 2'b10;
    n_press = 0;
    for (int i = 0; i < 4; i++) begin step(); if (key_if.press_pulse[0]) n_press++; end
    key_if.kin = 2'b11;
    for (int i = 0; i < 15; i++) begin step(); if (key_if.press_pulse[0]) n_press++; end
    check("glitch_press", 32'(n_press), 32'd0);
    key_if.kin = 2'b10;
    for (int i = 0; i < 5; i++) begin step(); if (key_if.press_pulse[0]) n_press++; end
    key_if.kin = 2'b11;
    for (int i = 0; i < 20; i++) begin step(); if (key_if.press_pulse[0]) n_press++; end
    check("window_press", 32'(n_press), 32'd1);

    // Simultaneous press, then release of key 1 only.
    key_if.kin = 2'b00;
    seen = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (key_if.press_pulse != '0 && seen == '0) seen = key_if.press_pulse;
    end
    check("dual_press", 32'(seen), 32'b11);
    key_if.kin = 2'b10;
    seen = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (key_if.release_pulse != '0 && seen == '0) seen = key_if.release_pulse;
    end
    check("single_release", 32'(seen), 32'b10);

    // One-cycle reset mid-hold with key 0 still down.
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    check("rst_kout", 32'(key_if.kout), 32'd0);
    rst = 1'b0;
    press_at = -1; n_rel = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (key_if.press_pulse[0] && press_at < 0) press_at = i;
      if (key_if.release_pulse != '0) n_rel++;
    end
    check("rst_press_latency", 32'(press_at), 32'(DEB + 2));
    check("rst_no_release", 32'(n_rel), 32'd0);
    key_if.kin = 2'b11;
    for (int i = 0; i < 20; i++) step();

    // Random pin activity with occasional resets and long holds.
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        len = $urandom_range(1, 2);
        for (int i = 0; i < len; i++) step();
        rst = 1'b0;
      end else begin
        key_if.kin = NK'($urandom_range(0, 3));
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 35) : $urandom_range(1, 8);
        for (int i = 0; i < len; i++) step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_debounce_multi.md
# key_debounce_multi

Parametrised multi-channel key debouncer. It takes N raw mechanical key inputs and produces a debounced, polarity-normalised level per key plus single-cycle press, release and long-press event pulses. It sits between the board key pins and the user-logic control FSMs, replacing per-key ad-hoc debounce counters. Each channel synchronises its input, filters it with a consecutive-sample counter, and keeps a hold timer.

## Interface
- N_KEYS, 4 — number of independent key channels (≥1)
- CLK_HZ, 100_000_000 — clk frequency in Hz
- DEBOUNCE_MS, 10 — required stable time in ms; DEB_CYC = CLK_HZ/1000*DEBOUNCE_MS, must be ≥2
- LONG_MS, 1000 — hold time for long-press in ms; LONG_CYC = CLK_HZ/1000*LONG_MS, must be > DEB_CYC
- ACTIVE_LOW, 1 — 1: key pin reads 0 when pressed; 0: reads 1 when pressed
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- kin  in  N_KEYS  raw asynchronous key pins
- kout  out  N_KEYS  debounced level, 1 = pressed (after polarity normalisation)
- press_pulse  out  N_KEYS  1-cycle pulse on debounced press
- release_pulse  out  N_KEYS  1-cycle pulse on debounced release
- long_pulse  out  N_KEYS  1-cycle pulse once per press when held LONG_CYC cycles

## Operation
- Per channel: 2-flop synchroniser on kin, then normalise: p = ACTIVE_LOW ? ~sync : sync (p=1 means pressed).
- Debounce counter deb_cnt, width $clog2(DEB_CYC). When p == kout, deb_cnt clears to 0. When p != kout, deb_cnt increments; on the edge where deb_cnt == DEB_CYC-1 and p != kout still holds, kout toggles and deb_cnt clears. kout therefore changes after exactly DEB_CYC consecutive differing samples. Any single agreeing sample restarts the count.
- Channel FSM states: RELEASED, PRESSED, LONG_HELD. The debounce flip to 1 takes RELEASED→PRESSED. PRESSED→LONG_HELD when hold_cnt reaches LONG_CYC-1. The debounce flip to 0 takes PRESSED or LONG_HELD→RELEASED. kout = (state != RELEASED).
- Hold counter hold_cnt, width $clog2(LONG_CYC). It is 0 in RELEASED and increments each cycle in PRESSED. It is held (no wrap) in LONG_HELD.
- press_pulse is asserted in the first cycle kout reads 1. release_pulse is asserted in the first cycle kout reads 0. long_pulse is asserted in the first cycle of LONG_HELD. All pulses are registered and last exactly 1 cycle.
- Release from LONG_HELD gives release_pulse only; no second long_pulse in the same press.
- Channels are fully independent. Simultaneous events on different channels all appear in the same cycle.
- Reset: synchroniser flops load the released pin level (ACTIVE_LOW ? 1 : 0). State = RELEASED. Both counters = 0. kout, press_pulse, release_pulse and long_pulse = 0. A key held through reset deassertion produces press_pulse DEB_CYC+2 cycles after reset release. Reset mid-press aborts without emitting release_pulse.

## Timing
- Latency from a kin edge to the kout/pulse change is 2 (synchroniser) + DEB_CYC cycles, given a clean edge.
- A glitch shorter than DEB_CYC synchronised cycles produces no output change.
- long_pulse fires LONG_CYC cycles after press_pulse, i.e. press_pulse at cycle t gives long_pulse at t+LONG_CYC.
- No combinational path from kin to any output.

## Structure
- Package key_pkg holds: the channel state enum (RELEASED, PRESSED, LONG_HELD); a function ms_to_cycles(clk_hz, ms); the released-level constant derivation.
- Sub-module key_debounce_ch implements one channel: synchroniser, debounce counter, FSM, hold counter and pulse registers.
- Top key_debounce_multi instantiates N_KEYS key_debounce_ch in a generate loop and elaborates parameter checks (DEB_CYC≥2, LONG_CYC>DEB_CYC).

## Test plan
Simulation parameters: CLK_HZ=1000, DEBOUNCE_MS=5, LONG_MS=20, giving DEB_CYC=5 and LONG_CYC=20. N_KEYS=2, ACTIVE_LOW=1.
- Reset, kin=2'b11 held → all outputs 0 for 50 cycles.
- kin[0] driven 0 at cycle 10 and held → kout[0]=1 and press_pulse[0] for one cycle at cycle 17. kout[1] stays 0.
- kin[0] low for 4 cycles, then high → no press_pulse, kout[0] stays 0. Repeat with 5 cycles → press detected.
- kin[0] held low 40 cycles after press → long_pulse[0] exactly once, 20 cycles after press_pulse. On release, release_pulse[0] once and no further long_pulse.
- Both kin bits fall in the same cycle → press_pulse=2'b11 in the same cycle. Release kin[1] only → release_pulse=2'b10.
- Key pressed, rst asserted 1 cycle mid-hold, key still low → outputs 0 during reset, no release_pulse, then press_pulse 7 cycles after rst deasserts.
